// File: rtl/floating_point_unit_pkg.sv
// Shared FPU types and constants used by the normalizer and its neighbours.
package floating_point_unit_pkg;

    localparam int SIG_WIDTH_DEFAULT = 48;
    localparam int EXP_BIAS          = 127;
    localparam int EXP_MAX           = 255;

    // Incoming biased exponent, and the one-bit-wider working exponent that
    // absorbs the normalization adjustment without wrapping.
    typedef logic signed [9:0]  exp_in_t;
    typedef logic signed [10:0] exp_work_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

endpackage

// File: rtl/count_leading_zeros.sv
// Parametric combinational leading-zero counter built as a binary-search tree.
module count_leading_zeros #(
    parameter int WIDTH       = 48,
    parameter int COUNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]       value_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   zero_o
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int PADDED = 1 << LEVELS;
    // Ones below the real input cap the tree count at WIDTH for any input.
    localparam logic [PADDED-1:0] PAD_ONES = (PADDED'(1) << (PADDED - WIDTH)) - PADDED'(1);

    logic [PADDED-1:0] window;
    logic [LEVELS-1:0] tree_count;
    logic              upper_zero;
    int                half;

    // Each level halves the window: an all-zero upper half adds its size to the count.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        window     = (PADDED'(value_i) << (PADDED - WIDTH)) | PAD_ONES;
        tree_count = '0;
        upper_zero = 1'b0;
        half       = 0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            half       = PADDED >> (lvl + 1);
            upper_zero = (window & ~({PADDED{1'b1}} >> half)) == '0;
            tree_count = (tree_count << 1) | LEVELS'(upper_zero);
            if (upper_zero) begin
                window = window << half;
            end
        end
    end

    assign zero_o  = ~|value_i;
    assign count_o = zero_o ? COUNT_WIDTH'(WIDTH) : COUNT_WIDTH'(tree_count);

endmodule

// File: rtl/floating_point_normalizer.sv
// Two-stage normalizer: stage 1 counts leading zeros, stage 2 aligns the
// significand, extracts the float32 fields plus guard/round/sticky, and flags
// overflow/underflow. Special values bypass the datapath untouched.
module floating_point_normalizer
    import floating_point_unit_pkg::*;
#(
    parameter int SIG_WIDTH = SIG_WIDTH_DEFAULT,
    parameter int LZC_WIDTH = $clog2(SIG_WIDTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic                 sign_i,
    input  logic signed [9:0]    exponent_i,
    input  logic [SIG_WIDTH-1:0] significand_i,
    input  logic                 special_i,
    input  logic [31:0]          special_value_i,
    output logic [31:0]          operand_o,
    output logic [2:0]           round_bits_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 valid_o
);

    logic [LZC_WIDTH-1:0] lzc_d;
    logic                 zero_d;

    logic                 s1_valid_q;
    logic                 s1_sign_q;
    exp_in_t              s1_exp_q;
    logic [SIG_WIDTH-1:0] s1_sig_q;
    logic                 s1_special_q;
    float32_t             s1_special_val_q;
    logic [LZC_WIDTH-1:0] s1_lzc_q;
    logic                 s1_zero_q;

    float32_t             operand_d, operand_q;
    round_bits_t          round_bits_d, round_bits_q;
    logic                 overflow_d, overflow_q;
    logic                 underflow_d, underflow_q;
    logic                 valid_o_q;

    logic [SIG_WIDTH-1:0] norm_sig;
    logic                 norm_lost;
    exp_work_t            e_norm;
    exp_work_t            amt_w;
    logic                 tiny;
    logic [LZC_WIDTH-1:0] den_shift;
    logic [SIG_WIDTH-1:0] lost_mask;
    logic [SIG_WIDTH-2:0] aligned;
    logic                 sticky;

    count_leading_zeros #(
        .WIDTH      (SIG_WIDTH),
        .COUNT_WIDTH(LZC_WIDTH)
    ) u_lzc (
        .value_i(significand_i),
        .count_o(lzc_d),
        .zero_o (zero_d)
    );

    // Stage-1 valid: flush beats stall, stall freezes, otherwise accept valid_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (!stall_i) begin
            s1_valid_q <= valid_i;
        end
    end

    // Stage-1 payload capture, qualified by an accepted operation.
    always_ff @(posedge clk_i) begin
        // NOTE: payload flops carry no reset; their contents are ignored while s1_valid_q is low.
        if (!stall_i && valid_i) begin
            s1_sign_q        <= sign_i;
            s1_exp_q         <= exponent_i;
            s1_sig_q         <= significand_i;
            s1_special_q     <= special_i;
            s1_special_val_q <= special_value_i;
            s1_lzc_q         <= lzc_d;
            s1_zero_q        <= zero_d;
        end
    end

    // Stage-2 alignment, denormal shift and field extraction.
    always_comb begin
        norm_sig  = s1_sig_q;
        norm_lost = 1'b0;
        if (s1_lzc_q == '0) begin
            // Integer part reached weight 2: shift right once, keep the lost bit for sticky.
            norm_sig  = s1_sig_q >> 1;
            norm_lost = s1_sig_q[0];
        end else begin
            norm_sig = s1_sig_q << (s1_lzc_q - LZC_WIDTH'(1));
        end
        e_norm = exp_work_t'(s1_exp_q) + exp_work_t'(1) - exp_work_t'(s1_lzc_q);

        tiny      = e_norm <= exp_work_t'(0);
        amt_w     = '0;
        den_shift = '0;
        if (tiny) begin
            amt_w     = exp_work_t'(1) - e_norm;
            den_shift = (amt_w > exp_work_t'(SIG_WIDTH + 2)) ? LZC_WIDTH'(SIG_WIDTH + 2)
                                                             : LZC_WIDTH'(amt_w);
        end
        aligned   = (SIG_WIDTH - 1)'(norm_sig >> den_shift);
        lost_mask = ~({SIG_WIDTH{1'b1}} << den_shift);
        sticky    = norm_lost | (|(norm_sig & lost_mask)) | (|aligned[SIG_WIDTH-28:0]);

        operand_d    = '0;
        round_bits_d = '0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        if (s1_special_q) begin
            operand_d = s1_special_val_q;
        end else if (s1_zero_q) begin
            operand_d.sign = s1_sign_q;
        end else if (e_norm >= exp_work_t'(EXP_MAX)) begin
            operand_d  = '{sign: s1_sign_q, exponent: 8'hFF, mantissa: 23'h0};
            overflow_d = 1'b1;
        end else begin
            operand_d.sign     = s1_sign_q;
            // A denormal keeps a zero field; the hidden-bit slot is always clear after a tiny shift.
            operand_d.exponent = tiny ? {7'b0, aligned[SIG_WIDTH-2]} : e_norm[7:0];
            operand_d.mantissa = aligned[SIG_WIDTH-3 -: 23];
            round_bits_d       = '{guard: aligned[SIG_WIDTH-26],
                                   round: aligned[SIG_WIDTH-27],
                                   sticky: sticky};
            underflow_d        = (operand_d.exponent == 8'h00) && (round_bits_d != '0);
        end
    end

    // Output stage: flush kills valid, stall freezes everything, payload loads only for live ops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o_q    <= 1'b0;
            operand_q    <= '0;
            round_bits_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (flush_i) begin
            valid_o_q <= 1'b0;
        end else if (!stall_i) begin
            valid_o_q <= s1_valid_q;
            if (s1_valid_q) begin
                operand_q    <= operand_d;
                round_bits_q <= round_bits_d;
                overflow_q   <= overflow_d;
                underflow_q  <= underflow_d;
            end
        end
    end

    assign operand_o    = operand_q;
    assign round_bits_o = round_bits_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;
    assign valid_o      = valid_o_q;

endmodule

// File: tb/tb_floating_point_normalizer.sv
// Scoreboard bench for floating_point_normalizer: directed vectors, stall,
// flush and reset sequences, then randomized traffic against a bit-weight model.
module tb_floating_point_normalizer;

    localparam int W = 48;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          stall_i;
    logic          flush_i;
    logic          valid_i;
    logic          sign_i;
    logic [9:0]    exponent_i;
    logic [W-1:0]  significand_i;
    logic          special_i;
    logic [31:0]   special_value_i;
    logic [31:0]   operand_o;
    logic [2:0]    round_bits_o;
    logic          overflow_o;
    logic          underflow_o;
    logic          valid_o;

    floating_point_normalizer #(.SIG_WIDTH(W)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .sign_i         (sign_i),
        .exponent_i     (exponent_i),
        .significand_i  (significand_i),
        .special_i      (special_i),
        .special_value_i(special_value_i),
        .operand_o      (operand_o),
        .round_bits_o   (round_bits_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .valid_o        (valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Response bundle: {operand[31:0], guard, round, sticky, overflow, underflow}.
    logic [36:0] dut_bundle;
    assign dut_bundle = {operand_o, round_bits_o, overflow_o, underflow_o};

    int          total = 0;
    int          bad   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] last_seen;
    bit          checked;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: place each set bit by its distance below the hidden-bit position.
    function automatic logic [36:0] ref_model(input bit s, input int e, input logic [W-1:0] sig,
                                              input bit sp, input logic [31:0] sv);
        int          p;
        int          big_e;
        int          top;
        int          rel;
        logic [22:0] mant;
        bit          g, r, st;
        logic [7:0]  field;
        if (sp) return {sv, 5'b0};
        if (sig == '0) return {s, 31'b0, 5'b0};
        p = 0;
        for (int i = 0; i < W; i++) if (sig[i]) p = i;
        big_e = e + p - (W - 2);
        if (big_e >= 255) return {s, 8'hFF, 23'h0, 3'b000, 1'b1, 1'b0};
        // Denormals anchor the hidden bit at the position whose exponent is 1.
        top  = (big_e >= 1) ? p : (W - 1 - e);
        mant = '0;
        g = 0; r = 0; st = 0;
        for (int i = 0; i < W; i++) begin
            if (sig[i]) begin
                rel = top - i;
                if (rel >= 1 && rel <= 23) mant[23 - rel] = 1'b1;
                else if (rel == 24) g = 1;
                else if (rel == 25) r = 1;
                else if (rel > 25) st = 1;
            end
        end
        field = (big_e >= 1) ? 8'(big_e) : 8'h00;
        return {s, field, mant, g, r, st, 1'b0, (field == 8'h00) && (g || r || st)};
    endfunction

    task automatic issue(input bit s, input int e, input logic [W-1:0] sig, input bit sp,
                         input logic [31:0] sv, input logic [36:0] req);
        valid_i         = 1'b1;
        sign_i          = s;
        exponent_i      = 10'(e);
        significand_i   = sig;
        special_i       = sp;
        special_value_i = sv;
        exp_q.push_back(req);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic issue_random();
        logic [W-1:0] sig;
        logic [31:0]  sv;
        int           e;
        bit           s, sp;
        s   = 1'($urandom_range(0, 1));
        sig = W'({$urandom(), $urandom()});
        if ($urandom_range(0, 19) == 0) sig = '0;
        else sig = sig >> $urandom_range(0, W - 1);
        case ($urandom_range(0, 3))
            0:       e = int'($urandom_range(0, 1023)) - 512;
            1:       e = int'($urandom_range(67, 187));
            2:       e = int'($urandom_range(0, 80)) - 40;
            default: e = int'($urandom_range(200, 300));
        endcase
        sp = ($urandom_range(0, 14) == 0);
        sv = $urandom();
        issue(s, e, sig, sp, sv, ref_model(s, e, sig, sp, sv));
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pop on each new output, re-compare while the output is held by a stall.
    initial begin
        checked = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                checked = 0;
            end else begin
                if (valid_o) begin
                    if (!checked) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_output: got %h, required no output", dut_bundle);
                        end else begin
                            last_seen = exp_q.pop_front();
                            check("output", dut_bundle, last_seen);
                        end
                        checked = 1;
                    end else begin
                        check("stall_hold", dut_bundle, last_seen);
                    end
                end
                if (!stall_i || flush_i) checked = 0;
            end
        end
    end

    initial begin
        rst_n_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        sign_i = 1'b0; exponent_i = '0; significand_i = '0;
        special_i = 1'b0; special_value_i = '0;

        #12;
        check("reset_outputs", dut_bundle, 37'h0);
        check("reset_valid", 37'(valid_o), 37'h0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(1);

        // Directed vectors with hand-derived responses.
        issue(0, 127, 48'h6000_0000_0000, 0, 0, {32'h3FC00000, 3'b000, 1'b0, 1'b0});
        issue(0, 127, 48'h8000_0000_0001, 0, 0, {32'h40000000, 3'b001, 1'b0, 1'b0});
        issue(0, 127, 48'h4000_0040_0000, 0, 0, {32'h3F800000, 3'b100, 1'b0, 1'b0});
        issue(0, 200, 48'h0000_0000_0001, 0, 0, {32'h4D000000, 3'b000, 1'b0, 1'b0});
        issue(0, 0,   48'h4000_0000_0000, 0, 0, {32'h00400000, 3'b000, 1'b0, 1'b0});
        issue(0, -30, 48'h4000_0000_0000, 0, 0, {32'h00000000, 3'b001, 1'b0, 1'b1});
        issue(0, 255, 48'h4000_0000_0000, 0, 0, {32'h7F800000, 3'b000, 1'b1, 1'b0});
        issue(1, 100, 48'h0000_0000_0000, 0, 0, {32'h80000000, 3'b000, 1'b0, 1'b0});
        issue(0, 127, 48'h8000_0000_0001, 1, 32'h7FC00000, {32'h7FC00000, 3'b000, 1'b0, 1'b0});
        drain();

        // Stall: A, B back to back, then freeze for three cycles, then C.
        issue_random();
        issue_random();
        stall_i = 1'b1;
        idle(3);
        check("stall_valid_held", 37'(valid_o), 37'h1);
        stall_i = 1'b0;
        issue_random();
        drain();

        // Flush together with stall: in-flight work disappears.
        issue_random();
        issue_random();
        stall_i = 1'b1;
        flush_i = 1'b1;
        idle(1);
        check("flush_valid", 37'(valid_o), 37'h0);
        exp_q.delete();
        stall_i = 1'b0;
        flush_i = 1'b0;
        idle(1);
        check("flush_kills_stage1", 37'(valid_o), 37'h0);
        idle(1);

        // Reset mid-stream.
        issue_random();
        issue_random();
        rst_n_i = 1'b0;
        #2;
        check("reset_mid_outputs", dut_bundle, 37'h0);
        check("reset_mid_valid", 37'(valid_o), 37'h0);
        exp_q.delete();
        idle(1);
        rst_n_i = 1'b1;
        idle(2);
        check("reset_mid_no_output", 37'(valid_o), 37'h0);

        // Randomized traffic with idle and stall cycles mixed in.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    stall_i = 1'b1;
                    idle(1);
                    stall_i = 1'b0;
                end
                1:       idle(1);
                default: issue_random();
            endcase
        end
        drain();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
